// File: rtl/alu_sequencer.sv
// Issue/control stage in front of the register-file + ALU datapath. It latches each
// instruction word and sequences it through operand read, ALU capture and write-back.
//
// state | meaning
// IDLE  | ready; accepts a word, NOP/HALT retire on the accept edge
// EXEC  | latched ALU op on A1/A2/opcode, ALU_result captured at end of cycle
// WB    | register-file write plus done pulse for ALU or LI
// HALT  | HALT executed; nothing accepted or written until RST
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       A1,
    output logic [4:0]       A2,
    output logic [4:0]       A3,
    output logic             WE3,
    output logic [31:0]      WD3,
    output logic [1:0]       opcode,
    input  logic [31:0]      ALU_result,
    output logic             done_valid,
    output logic [4:0]       done_rd,
    output logic [31:0]      done_data,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    localparam logic [1:0] K_ALU  = 2'b00;
    localparam logic [1:0] K_LI   = 2'b01;
    localparam logic [1:0] K_NOP  = 2'b10;
    localparam logic [1:0] K_HALT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_HALT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_instr;
    logic [31:0]      r_result;
    logic [CNT_W-1:0] r_retired;
    logic             w_accept;
    logic             w_retire;
    logic [1:0]       w_in_kind;
    logic [31:0]      w_wb_data;

    assign w_in_kind = instr[31:30];
    assign w_accept  = instr_valid && instr_ready;
    assign w_retire  = (r_state == S_WB) ||
                       (w_accept && ((w_in_kind == K_NOP) || (w_in_kind == K_HALT)));
    assign w_wb_data = (r_instr[31:30] == K_ALU) ? r_result : {16'b0, r_instr[15:0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reset branch also blocks the WB retire, so a reset during WB or EXEC discards the op.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_instr   <= '0;
            r_result  <= '0;
            r_retired <= '0;
        end else begin
            if (w_accept) begin
                r_instr <= instr;
            end
            if (r_state == S_EXEC) begin
                r_result <= ALU_result;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (w_in_kind)
                        K_ALU:   w_state_nxt = S_EXEC;
                        K_LI:    w_state_nxt = S_WB;
                        K_NOP:   w_state_nxt = S_IDLE;
                        default: w_state_nxt = S_HALT;
                    endcase
                end
            end
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_HALT;
        endcase
    end

    // Every output is forced to its reset value while RST is high, not only after the edge.
    always_comb begin
        instr_ready = 1'b0;
        A1          = '0;
        A2          = '0;
        A3          = '0;
        WE3         = 1'b0;
        WD3         = '0;
        opcode      = '0;
        done_valid  = 1'b0;
        done_rd     = '0;
        done_data   = '0;
        halted      = 1'b0;
        retired     = '0;
        if (!RST) begin
            instr_ready = (r_state == S_IDLE);
            halted      = (r_state == S_HALT);
            retired     = r_retired;
            A1          = r_instr[22:18];
            A2          = r_instr[17:13];
            opcode      = r_instr[29:28];
            if (r_state == S_WB) begin
                A3         = r_instr[27:23];
                WE3        = 1'b1;
                WD3        = w_wb_data;
                done_valid = 1'b1;
                done_rd    = r_instr[27:23];
                done_data  = w_wb_data;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a register file + ALU stand-in around the DUT, and an
// instruction-level model that predicts every write, timing point and count.
module tb_alu_sequencer;
    logic        CLK;
    logic        RST;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  A1, A2, A3;
    logic        WE3;
    logic [31:0] WD3;
    logic [1:0]  opcode;
    logic [31:0] ALU_result;
    logic        done_valid;
    logic [4:0]  done_rd;
    logic [31:0] done_data;
    logic        halted;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    logic [31:0] env_rf [32];
    logic [31:0] m_rf   [32];
    int unsigned m_ret;

    alu_sequencer #(.CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
        .opcode(opcode), .ALU_result(ALU_result), .done_valid(done_valid),
        .done_rd(done_rd), .done_data(done_data), .halted(halted), .retired(retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for the external register file and 2-bit ALU.
    always @(posedge CLK) begin
        if (WE3) env_rf[A3] <= WD3;
    end

    always_comb begin
        case (opcode)
            2'b00:   ALU_result = env_rf[A1] + env_rf[A2];
            2'b01:   ALU_result = env_rf[A1] - env_rf[A2];
            2'b10:   ALU_result = env_rf[A1] << env_rf[A2][4:0];
            default: ALU_result = env_rf[A1] >> env_rf[A2][4:0];
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_alu(input logic [1:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {2'b00, op, rd, rs1, rs2, 13'($urandom)};
    endfunction

    function automatic logic [31:0] f_li(input logic [4:0] rd, input logic [15:0] imm);
        return {2'b01, 2'($urandom), rd, 7'($urandom), imm};
    endfunction

    function automatic logic [31:0] f_nop();
        return {2'b10, 30'($urandom)};
    endfunction

    function automatic logic [31:0] f_halt();
        return {2'b11, 30'($urandom)};
    endfunction

    // Reference ALU semantics computed in 64-bit arithmetic and truncated.
    function automatic logic [31:0] m_alu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] wide;
        case (op)
            2'b00:   wide = {32'b0, a} + {32'b0, b};
            2'b01:   wide = {32'b0, a} + (64'h1_0000_0000 - {32'b0, b});
            2'b10:   wide = {32'b0, a} * (64'd1 << b[4:0]);
            default: wide = {32'b0, a} / (64'd1 << b[4:0]);
        endcase
        return wide[31:0];
    endfunction

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_wb(input logic [4:0] rd, input logic [31:0] val);
        chk("wb_ready", instr_ready, 0);
        chk("wb_we3", WE3, 1);
        chk("wb_a3", A3, rd);
        chk("wb_wd3", WD3, val);
        chk("wb_done_valid", done_valid, 1);
        chk("wb_done_rd", done_rd, rd);
        chk("wb_done_data", done_data, val);
    endtask

    // Issue one word from IDLE and check its whole passage; returns one cycle after retirement.
    task automatic issue(input logic [31:0] w);
        logic [31:0] res;
        logic [4:0]  rd;
        rd = w[27:23];
        instr_valid = 1'b1;
        instr       = w;
        @(negedge CLK);
        chk("idle_ready", instr_ready, 1);
        chk("idle_we3", WE3, 0);
        chk("idle_done_valid", done_valid, 0);
        chk("idle_halted", halted, 0);
        chk("retired", retired, 32'(m_ret[15:0]));
        next_cyc();
        instr_valid = 1'b0;
        case (w[31:30])
            2'b00: begin
                res = m_alu(w[29:28], m_rf[w[22:18]], m_rf[w[17:13]]);
                instr_valid = 1'($urandom);
                instr       = $urandom;
                @(negedge CLK);
                chk("exec_ready", instr_ready, 0);
                chk("exec_a1", A1, w[22:18]);
                chk("exec_a2", A2, w[17:13]);
                chk("exec_opcode", opcode, w[29:28]);
                chk("exec_we3", WE3, 0);
                chk("exec_done_valid", done_valid, 0);
                next_cyc();
                instr_valid = 1'($urandom);
                instr       = $urandom;
                @(negedge CLK);
                chk_wb(rd, res);
                chk("wb_a1_stable", A1, w[22:18]);
                chk("wb_opcode_stable", opcode, w[29:28]);
                next_cyc();
                m_rf[rd] = res;
                m_ret++;
            end
            2'b01: begin
                res = {16'b0, w[15:0]};
                instr_valid = 1'($urandom);
                instr       = $urandom;
                @(negedge CLK);
                chk_wb(rd, res);
                next_cyc();
                m_rf[rd] = res;
                m_ret++;
            end
            2'b10: m_ret++;
            default: begin
                m_ret++;
                @(negedge CLK);
                chk("halt_halted", halted, 1);
                chk("halt_ready", instr_ready, 0);
                next_cyc();
            end
        endcase
        instr_valid = 1'b0;
    endtask

    logic [31:0] hold_words [4];
    int          acc [4];
    int          idx;
    logic [31:0] w;
    int unsigned k;

    initial begin
        RST = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        m_ret = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;

        // Reset values, both while RST is high and after the reset edge.
        #1;
        instr_valid = 1'b1;
        instr = f_li(5'd9, 16'hABCD);
        @(negedge CLK);
        chk("rst_ready", instr_ready, 0);
        chk("rst_we3", WE3, 0);
        chk("rst_done_valid", done_valid, 0);
        next_cyc();
        @(negedge CLK);
        chk("rst_retired", retired, 0);
        chk("rst_halted", halted, 0);
        chk("rst_a1", A1, 0);
        chk("rst_wd3", WD3, 0);
        next_cyc();
        RST = 1'b0;
        instr_valid = 1'b0;

        // Directed plan: loads, then ADD / SUB / SHL on their 3-cycle cadence.
        issue(f_li(5'd1, 16'd5));
        issue(f_li(5'd2, 16'd3));
        @(negedge CLK);
        chk("retired_after_li", retired, 2);
        next_cyc();
        issue(f_alu(2'b00, 5'd3, 5'd1, 5'd2));
        chk("add_value", m_rf[3], 32'd8);
        issue(f_alu(2'b01, 5'd4, 5'd2, 5'd1));
        chk("env_sub", env_rf[4], 32'hFFFF_FFFE);
        issue(f_alu(2'b10, 5'd5, 5'd1, 5'd2));
        chk("env_shl", env_rf[5], 32'd40);

        // instr_valid held high through ALU, NOP, NOP, LI.
        hold_words[0] = f_alu(2'b00, 5'd6, 5'd1, 5'd2);
        hold_words[1] = f_nop();
        hold_words[2] = f_nop();
        hold_words[3] = f_li(5'd7, 16'h1234);
        for (int i = 0; i < 4; i++) acc[i] = -1;
        idx = 0;
        instr_valid = 1'b1;
        instr = hold_words[0];
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (c == 6) begin
                chk("hold_li_done", done_valid, 1);
                chk("hold_li_rd", done_rd, 7);
                chk("hold_li_data", done_data, 32'h1234);
            end
            if (c == 7) chk("hold_retired", retired, 32'((m_ret + 4) & 16'hFFFF));
            if (instr_valid && instr_ready && idx < 4) begin
                acc[idx] = c;
                idx++;
            end
            next_cyc();
            if (idx < 4) instr = hold_words[idx];
            else instr_valid = 1'b0;
        end
        chk("hold_acc0", acc[0], 0);
        chk("hold_acc1", acc[1], 3);
        chk("hold_acc2", acc[2], 4);
        chk("hold_acc3", acc[3], 5);
        m_rf[6] = m_rf[1] + m_rf[2];
        m_rf[7] = 32'h1234;
        m_ret += 4;
        chk("hold_env_r6", env_rf[6], 32'd8);

        // Seed every register, then run a random instruction mix.
        for (int r = 0; r < 32; r++) issue(f_li(5'(r), 16'($urandom)));
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 9);
            if (k < 5) w = f_alu(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            else if (k < 8) w = f_li(5'($urandom), 16'($urandom));
            else w = f_nop();
            issue(w);
        end
        for (int r = 0; r < 32; r++) chk("rf_final", env_rf[r], m_rf[r]);

        // Reset in the WB cycle of an ADD: no write, no done pulse.
        w = f_alu(2'b00, 5'd9, 5'd10, 5'd11);
        instr_valid = 1'b1;
        instr = w;
        @(negedge CLK);
        chk("rwb_ready", instr_ready, 1);
        next_cyc();
        instr_valid = 1'b0;
        next_cyc();
        RST = 1'b1;
        @(negedge CLK);
        chk("rwb_we3", WE3, 0);
        chk("rwb_done_valid", done_valid, 0);
        next_cyc();
        @(negedge CLK);
        chk("rwb_r9_kept", env_rf[9], m_rf[9]);
        chk("rwb_retired", retired, 0);
        chk("rwb_ready_rst", instr_ready, 0);
        chk("rwb_a3", A3, 0);
        chk("rwb_done_data", done_data, 0);
        next_cyc();
        RST = 1'b0;
        m_ret = 0;

        // HALT then more valid words: nothing accepted or written until reset.
        issue(f_li(5'd12, 16'h0BEE));
        issue(f_halt());
        for (int c = 0; c < 6; c++) begin
            instr_valid = 1'b1;
            instr = (c % 2 == 0) ? f_li(5'd12, 16'h7777) : f_nop();
            @(negedge CLK);
            chk("halt_ready_hold", instr_ready, 0);
            chk("halt_flag_hold", halted, 1);
            chk("halt_we3", WE3, 0);
            chk("halt_retired", retired, 32'(m_ret[15:0]));
            next_cyc();
        end
        chk("halt_r12_kept", env_rf[12], 32'h0BEE);
        RST = 1'b1;
        instr_valid = 1'b0;
        next_cyc();
        RST = 1'b0;
        m_ret = 0;
        @(negedge CLK);
        chk("post_halt_ready", instr_ready, 1);
        chk("post_halt_flag", halted, 0);
        chk("post_halt_retired", retired, 0);
        next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue/control stage sitting directly upstream of the register-file + ALU datapath (`project4`). It accepts 32-bit instruction words over a valid/ready handshake and decodes them. It sequences each word through the register-file read ports, the 2-bit ALU and the register-file write port, then reports each retired result. The ALU itself stays outside this block; its combinational result returns on `ALU_result`.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `CLK`  in  1  sole clock; all state updates on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  upstream has an instruction word.
- `instr`  in  32  instruction word; sampled only on an accept edge.
- `instr_ready`  out  1  block can accept an instruction this cycle.
- `A1`, `A2`  out  5  register-file read addresses (rs1, rs2).
- `A3`  out  5  register-file write address (rd).
- `WE3`  out  1  register-file write enable.
- `WD3`  out  32  register-file write data.
- `opcode`  out  2  ALU op: 00 add, 01 sub, 10 shl, 11 shr.
- `ALU_result`  in  32  combinational ALU output for `A1`/`A2`/`opcode`.
- `done_valid`  out  1  one-cycle pulse: a write-back instruction is retiring.
- `done_rd`  out  5  destination of the retiring instruction.
- `done_data`  out  32  value written.
- `halted`  out  1  HALT has been executed.
- `retired`  out  CNT_W  count of retired instructions (ALU, LI, NOP, HALT).

## Operation
Instruction fields:
- `[31:30]` kind: 00 ALU, 01 LI, 10 NOP, 11 HALT.
- `[29:28]` ALU op.
- `[27:23]` rd.
- `[22:18]` rs1.
- `[17:13]` rs2.
- `[15:0]` LI immediate, zero-extended to 32 bits. rs2 is ignored for LI.

Accept occurs on a rising edge with `instr_valid && instr_ready`. The word is latched into an internal instruction register at that edge.

FSM states are IDLE, EXEC, WB and HALT.
- IDLE: `instr_ready`=1. On accept:
  - ALU → EXEC.
  - LI → WB.
  - NOP → stay in IDLE; `retired` increments.
  - HALT → HALT; `retired` increments.
- EXEC: drive `A1`=rs1, `A2`=rs2, `opcode`=op from the latched word. Capture `ALU_result` into a 32-bit result register at the end of the cycle. → WB.
- WB: `A3`=rd, `WD3`=result register (ALU) or immediate (LI), `WE3`=1, `done_valid`=1, `done_rd`=rd, `done_data`=`WD3`. `retired` increments at the end of the cycle. → IDLE.
- HALT: `instr_ready`=0 and `halted`=1 until `RST`. No further writes.

Datapath rules:
- `A1`, `A2` and `opcode` hold the latched fields in every state, so they stay stable through WB.
- ALU arithmetic is defined by the ALU; the block forwards its 32-bit result unmodified, with no width change.
- Writes to rd=0 are ordinary writes; there is no hard-wired zero register.
- `retired` wraps from all-ones to 0 silently.

## Timing
Reset values (while `RST`=1 and after the reset edge):
- `instr_ready`=0, `WE3`=0, `done_valid`=0, `halted`=0, `retired`=0.
- `A1`/`A2`/`A3`/`opcode`/`WD3`/`done_rd`/`done_data`=0.
- State = IDLE.

After reset:
- `instr_ready` is 1 in the first cycle after `RST` deasserts, with no wait state.
- `instr_ready` is a function of state only; it never depends on `instr_valid`.

Per-kind timing, with the accept at edge N:
- ALU: EXEC in cycle N+1; WB in cycle N+2, with the register write committing at edge N+3; `instr_ready` high again in cycle N+3. Issue rate is one ALU op per 3 cycles.
- LI: WB in cycle N+1; `instr_ready` high again in cycle N+2.
- NOP: `instr_ready` stays high, so back-to-back NOPs sustain 1/cycle.

Hazards and reset:
- No hazard logic is needed: each instruction fully commits before the next is accepted, so an ALU op reading a register written by the previous instruction sees the new value.
- `WE3` and `done_valid` are gated combinationally by `RST`. A reset asserted during WB commits no write and emits no done pulse.
- Reset during EXEC discards the instruction; `retired` is not incremented.
- `instr_valid` held high while `instr_ready`=0 must be ignored. The word is not consumed until a later accept edge, and `instr` may change freely while not ready.

## Test plan
- Reset, then issue LI r1←5 and LI r2←3 → two `done_valid` pulses with `done_data`=5 and 3, each one cycle after its accept; `retired`=2.
- ADD r3←r1+r2 (after the loads) → `A1`=1, `A2`=2, `opcode`=00 in EXEC; WB cycle has `WE3`=1, `A3`=3, `WD3`=8; `instr_ready` low for exactly 2 cycles.
- SUB r4←r2−r1 → `WD3`=0xFFFFFFFE. SHL r5←r1<<r2 → `WD3`=40. Each follows the 3-cycle cadence.
- Hold `instr_valid`=1 continuously with ALU, NOP, NOP, LI → accepts at cycles 0, 3, 4, 5. LI write occurs in cycle 6; `retired`=4 after cycle 6.
- `RST` asserted in the WB cycle of an ADD → `WE3`=0 and `done_valid`=0 that cycle; the target register is unchanged; all outputs at reset values on the next cycle.
- HALT, then more valid words → `halted`=1, `instr_ready`=0 indefinitely, no `WE3`; `RST` clears `halted` and restores `instr_ready`=1 on the following cycle.
